// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button gesture front end.
// The gesture timer width comes from the larger of the long-press and double-click windows.
package button_pkg;

   typedef enum logic [2:0] {
      S_IDLE           = 3'd0,
      S_PRESSED        = 3'd1,
      S_LONG_HELD      = 3'd2,
      S_WAIT_SECOND    = 3'd3,
      S_SECOND_PRESSED = 3'd4
   } gesture_state_t;

   function automatic int max_ticks(input int long_ticks, input int dclick_ticks);
      return (long_ticks > dclick_ticks) ? long_ticks : dclick_ticks;
   endfunction

   // One spare bit so the saturation value itself is always representable.
   function automatic int timer_w(input int long_ticks, input int dclick_ticks);
      return $clog2(max_ticks(long_ticks, dclick_ticks)) + 1;
   endfunction

endpackage

// File: rtl/button_gesture_decoder_sync_debounce.sv
// Two-flop synchronizer and stable-count debouncer for one raw button,
// with a registered pulse one cycle after each debounced rising edge.
module sync_debounce #(
   parameter int BOUNCE_TICKS = 250
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bouncy_in,
   output logic debounced_out,
   output logic press_edge
);

   localparam int CNT_W = $clog2(BOUNCE_TICKS);
   localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(BOUNCE_TICKS - 1);

   logic [1:0]       sync_ff;
   logic             sync_in;
   logic [CNT_W-1:0] cnt;
   logic             deb_q;

   assign sync_in = sync_ff[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_ff <= '0;
      else        sync_ff <= {sync_ff[0], bouncy_in};
   end

   // Any cycle of agreement restarts the count, so only an unbroken run flips the level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         debounced_out <= 1'b0;
      end else if (sync_in != debounced_out) begin
         if (cnt == CNT_HIT) begin
            debounced_out <= ~debounced_out;
            cnt           <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q      <= 1'b0;
         press_edge <= 1'b0;
      end else begin
         deb_q      <= debounced_out;
         press_edge <= debounced_out & ~deb_q;
      end
   end

endmodule

// File: rtl/button_gesture_decoder.sv
// Push-button front end: debounced level, press edge, and short/long/double
// gesture classification as registered single-cycle event pulses.
module button_gesture_decoder
   import button_pkg::*;
#(
   parameter int BOUNCE_TICKS = 250,
   parameter int LONG_TICKS   = 50_000_000,
   parameter int DCLICK_TICKS = 12_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bouncy_in,
   output logic debounced_out,
   output logic press_edge,
   output logic short_press,
   output logic long_press,
   output logic double_press,
   output logic busy
);

   localparam int TIMER_W = timer_w(LONG_TICKS, DCLICK_TICKS);
   localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(max_ticks(LONG_TICKS, DCLICK_TICKS));
   localparam logic [TIMER_W-1:0] LONG_HIT   = TIMER_W'(LONG_TICKS - 1);
   localparam logic [TIMER_W-1:0] DCLICK_HIT = TIMER_W'(DCLICK_TICKS - 1);

   gesture_state_t     state, state_nxt;
   logic [TIMER_W-1:0] timer;
   logic               deb_q;
   logic               rise, fall;
   logic               short_nxt, long_nxt, double_nxt;

   sync_debounce #(
      .BOUNCE_TICKS(BOUNCE_TICKS)
   ) u_sync_debounce (
      .clk          (clk),
      .rst_n        (rst_n),
      .bouncy_in    (bouncy_in),
      .debounced_out(debounced_out),
      .press_edge   (press_edge)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) deb_q <= 1'b0;
      else        deb_q <= debounced_out;
   end

   assign rise = debounced_out & ~deb_q;
   assign fall = ~debounced_out & deb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Edges take priority over timer thresholds landing in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (rise) state_nxt = S_PRESSED;
         S_PRESSED:
            if (fall)                   state_nxt = S_WAIT_SECOND;
            else if (timer == LONG_HIT) state_nxt = S_LONG_HELD;
         S_LONG_HELD:
            if (fall) state_nxt = S_IDLE;
         S_WAIT_SECOND:
            if (rise)                     state_nxt = S_SECOND_PRESSED;
            else if (timer == DCLICK_HIT) state_nxt = S_IDLE;
         S_SECOND_PRESSED:
            if (fall)                   state_nxt = S_IDLE;
            else if (timer == LONG_HIT) state_nxt = S_LONG_HELD;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // Each pulse is tied to one distinct transition, so they are mutually exclusive.
   always_comb begin
      short_nxt  = 1'b0;
      long_nxt   = 1'b0;
      double_nxt = 1'b0;
      if (state == S_WAIT_SECOND && state_nxt == S_IDLE)    short_nxt  = 1'b1;
      if (state != S_LONG_HELD && state_nxt == S_LONG_HELD) long_nxt   = 1'b1;
      if (state == S_SECOND_PRESSED && state_nxt == S_IDLE) double_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (state_nxt != state) begin
         timer <= '0;
      end else if (timer != TIMER_MAX) begin
         timer <= timer + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_press <= 1'b0;
         busy         <= 1'b0;
      end else begin
         short_press  <= short_nxt;
         long_press   <= long_nxt;
         double_press <= double_nxt;
         busy         <= (state != S_IDLE);
      end
   end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Self-checking bench: timestamp-based gesture model checked every cycle,
// directed scenarios with literal latency checks, then randomized press trains.
module tb_button_gesture_decoder;

   localparam int B    = 4;
   localparam int L    = 20;
   localparam int D    = 10;
   localparam int MAXC = 16384;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bouncy_in = 1'b0;
   logic debounced_out, press_edge, short_press, long_press, double_press, busy;

   int tests = 0;
   int failed = 0;
   int cyc = 0;

   button_gesture_decoder #(
      .BOUNCE_TICKS(B),
      .LONG_TICKS  (L),
      .DCLICK_TICKS(D)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bouncy_in    (bouncy_in),
      .debounced_out(debounced_out),
      .press_edge   (press_edge),
      .short_press  (short_press),
      .long_press   (long_press),
      .double_press (double_press),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Model state: input/sync history plus gesture timestamps (-1 = none).
   bit in_hist[MAXC];
   bit sync_hist[MAXC];
   bit busy_hist[MAXC];
   bit deb_m;
   int g_start = -1, g_rel = -1;
   bit second_p, held_long;
   bit e_short, e_long, e_double, e_edge, e_busy;
   bit dn, rs, fl, all_diff, prev_dut_deb;

   // DUT event observations for the directed latency checks.
   int obs_rise = -1, obs_fall = -1, obs_short = -1, obs_long = -1, obs_double = -1;
   int n_short = 0, n_long = 0, n_double = 0, n_edge = 0;

   initial begin
      int n;
      forever begin
         @(negedge clk);
         n = cyc;
         if (n < MAXC) begin
            in_hist[n]   = bouncy_in;
            sync_hist[n] = (n >= 2) ? in_hist[n-2] : 1'b0;
            busy_hist[n] = busy;
            if (!rst_n) begin
               check("reset_outputs",
                     int'(debounced_out) + int'(press_edge) + int'(short_press) +
                     int'(long_press) + int'(double_press) + int'(busy), 0);
               deb_m = 0; g_start = -1; g_rel = -1; second_p = 0; held_long = 0;
               e_short = 0; e_long = 0; e_double = 0; e_edge = 0; e_busy = 0;
               prev_dut_deb = 0;
            end else begin
               // Level flips once the last B synchronized samples all disagree with it.
               dn = deb_m;
               if (n >= B) begin
                  all_diff = 1;
                  for (int k = 1; k <= B; k++)
                     if (sync_hist[n-k] == deb_m) all_diff = 0;
                  if (all_diff) dn = !deb_m;
               end
               rs = dn && !deb_m;
               fl = !dn && deb_m;

               check("debounced_out", int'(debounced_out), int'(dn));
               check("press_edge",    int'(press_edge),    int'(e_edge));
               check("short_press",   int'(short_press),   int'(e_short));
               check("long_press",    int'(long_press),    int'(e_long));
               check("double_press",  int'(double_press),  int'(e_double));
               check("busy",          int'(busy),          int'(e_busy));

               if (debounced_out && !prev_dut_deb) obs_rise = n;
               if (!debounced_out && prev_dut_deb) obs_fall = n;
               if (short_press)  begin obs_short  = n; n_short++;  end
               if (long_press)   begin obs_long   = n; n_long++;   end
               if (double_press) begin obs_double = n; n_double++; end
               if (press_edge)   n_edge++;
               prev_dut_deb = debounced_out;

               // Expectations for the next cycle, from edge times and elapsed durations.
               e_busy   = (g_start >= 0) || (g_rel >= 0) || held_long;
               e_edge   = rs;
               e_short  = 0;
               e_long   = 0;
               e_double = 0;
               if (held_long) begin
                  if (fl) held_long = 0;
               end else if (g_start >= 0) begin
                  if (fl) begin
                     if (second_p) begin e_double = 1; second_p = 0; end
                     else g_rel = n;
                     g_start = -1;
                  end else if (n == g_start + L) begin
                     e_long = 1; held_long = 1; g_start = -1; second_p = 0;
                  end
               end else if (g_rel >= 0) begin
                  if (rs) begin g_start = n; second_p = 1; g_rel = -1; end
                  else if (n == g_rel + D) begin e_short = 1; g_rel = -1; end
               end else if (rs) begin
                  g_start = n; second_p = 0;
               end
               deb_m = dn;
            end
         end
      end
   end

   task automatic drive(input bit v, input int cycles);
      bouncy_in = v;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_edge, t_rel, s0, l0, d0, len;
      bit v;
      rst_n = 1'b0;
      bouncy_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(0, 5);

      // Bounce rejection followed by a short press of 8 debounced cycles.
      for (int i = 0; i < 15; i++) drive(bit'(i % 2), 2);
      check("bounce_no_events", n_short + n_long + n_double + n_edge, 0);
      check("bounce_no_level", obs_rise, -1);
      t_edge = cyc;
      drive(1, 8);
      t_rel = cyc;
      drive(0, 30);
      check("bounce_rise_latency", obs_rise - t_edge, 6);
      check("single_press_edge", n_edge, 1);
      check("fall_latency", obs_fall - t_rel, 6);
      check("short_latency", obs_short - obs_fall, 11);
      check("short_count", n_short, 1);
      check("busy_at_short", int'(busy_hist[obs_short]), 1);
      check("busy_after_short", int'(busy_hist[obs_short+1]), 0);

      // Long press.
      s0 = n_short; l0 = n_long;
      drive(1, 40);
      drive(0, 40);
      check("long_latency", obs_long - obs_rise, 21);
      check("long_count", n_long - l0, 1);
      check("long_no_short", n_short - s0, 0);

      // Double press.
      s0 = n_short; d0 = n_double;
      drive(1, 5); drive(0, 6); drive(1, 5); drive(0, 30);
      check("double_latency", obs_double - obs_fall, 1);
      check("double_count", n_double - d0, 1);
      check("double_no_short", n_short - s0, 0);

      // Second rise exactly at the last gap cycle still counts as a double.
      s0 = n_short; d0 = n_double;
      drive(1, 5); drive(0, 10); drive(1, 5); drive(0, 30);
      check("gap_edge_double", n_double - d0, 1);
      check("gap_edge_no_short", n_short - s0, 0);

      // One cycle later the first press times out and the second is a fresh gesture.
      s0 = n_short; d0 = n_double;
      drive(1, 5); drive(0, 11); drive(1, 5); drive(0, 30);
      check("gap_over_shorts", n_short - s0, 2);
      check("gap_over_no_double", n_double - d0, 0);

      // Release on the long threshold cycle: the fall wins.
      s0 = n_short; l0 = n_long;
      drive(1, 20); drive(0, 30);
      check("hold_edge_short", n_short - s0, 1);
      check("hold_edge_no_long", n_long - l0, 0);
      s0 = n_short; l0 = n_long;
      drive(1, 21); drive(0, 30);
      check("hold_over_long", n_long - l0, 1);
      check("hold_over_no_short", n_short - s0, 0);

      // Randomized press/release trains with occasional glitches.
      v = 1'b1;
      for (int i = 0; i < 150; i++) begin
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 26));
         drive(v, len);
         v = !v;
      end
      drive(0, 40);

      // Reset while waiting for a second press.
      s0 = n_short;
      drive(1, 5);
      drive(0, 9);
      check("pre_reset_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            int'(debounced_out) + int'(press_edge) + int'(short_press) +
            int'(long_press) + int'(double_press) + int'(busy), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(0, 30);
      check("reset_no_short", n_short - s0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
